// File: rtl/vga_timing_pkg.sv
// Shared types, timing constant sets and helpers for the VGA raster timing generator.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STOP_PEND = 2'd2
  } state_e;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
    logic        hs_pol;
    logic        vs_pol;
  } vga_timing_t;

  localparam vga_timing_t VGA_640X480_60 = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
    hs_pol: 1'b0, vs_pol: 1'b0
  };

  localparam vga_timing_t VGA_800X600_60 = '{
    h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
    v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
    hs_pol: 1'b1, vs_pol: 1'b1
  };

  function automatic int unsigned axis_total(input int unsigned sync_len,
                                             input int unsigned bp_len,
                                             input int unsigned active_len,
                                             input int unsigned fp_len);
    return sync_len + bp_len + active_len + fp_len;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Single raster axis: wrapping position counter with sync and active-area decode.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FP     = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BP     = 48,
  parameter int unsigned CW     = 11
) (
  input  logic          vga_clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          adv,
  output logic          wrap_c,
  output logic          sync_c,
  output logic          active_c,
  output logic [CW-1:0] pos_c
);

  localparam int unsigned TOTAL   = axis_total(SYNC, BP, ACTIVE, FP);
  localparam int unsigned A_START = SYNC + BP;
  localparam int unsigned A_END   = A_START + ACTIVE;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    wrap_c   = adv && (cnt_q == CW'(TOTAL - 1));
    sync_c   = cnt_q < CW'(SYNC);
    active_c = (cnt_q >= CW'(A_START)) && (cnt_q < CW'(A_END));
    pos_c    = active_c ? (cnt_q - CW'(A_START)) : '0;

    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (adv) begin
      cnt_d = wrap_c ? '0 : (cnt_q + CW'(1));
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with frame-boundary start/stop.
// Optional 2x pixel-replication outputs under VGA_TIMING_GEN_PIXREP2_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_640X480_60.h_active,
  parameter int unsigned H_FP     = VGA_640X480_60.h_fp,
  parameter int unsigned H_SYNC   = VGA_640X480_60.h_sync,
  parameter int unsigned H_BP     = VGA_640X480_60.h_bp,
  parameter int unsigned V_ACTIVE = VGA_640X480_60.v_active,
  parameter int unsigned V_FP     = VGA_640X480_60.v_fp,
  parameter int unsigned V_SYNC   = VGA_640X480_60.v_sync,
  parameter int unsigned V_BP     = VGA_640X480_60.v_bp,
  parameter bit          HS_POL   = VGA_640X480_60.hs_pol,
  parameter bit          VS_POL   = VGA_640X480_60.vs_pol,
  parameter int unsigned CW       = 11
) (
  input  logic          vga_clk,
  input  logic          reset,
  input  logic          enable,
  output logic          HS,
  output logic          VS,
  output logic          blank_n,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic          running
`ifdef VGA_TIMING_GEN_PIXREP2_EN
  ,
  output logic [CW-2:0] xs,
  output logic [CW-2:0] ys,
  output logic          rep_fetch
`endif
);

  state_e        state_q, state_d;
  logic          run_c;
  logic          h_wrap_c, v_wrap_c;
  logic          h_sync_c, v_sync_c;
  logic          h_active_c, v_active_c;
  logic [CW-1:0] h_pos_c, v_pos_c;

  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          blank_n_q, blank_n_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          running_q, running_d;
`ifdef VGA_TIMING_GEN_PIXREP2_EN
  logic [CW-2:0] xs_q, xs_d;
  logic [CW-2:0] ys_q, ys_d;
  logic          rep_fetch_q, rep_fetch_d;
`endif

  assign run_c = (state_q != IDLE);

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .CW     (CW)
  ) u_h_cnt (
    .vga_clk  (vga_clk),
    .reset    (reset),
    .clr      (!run_c),
    .adv      (run_c),
    .wrap_c   (h_wrap_c),
    .sync_c   (h_sync_c),
    .active_c (h_active_c),
    .pos_c    (h_pos_c)
  );

  // Vertical axis steps once per horizontal wrap; its wrap marks the frame end.
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .CW     (CW)
  ) u_v_cnt (
    .vga_clk  (vga_clk),
    .reset    (reset),
    .clr      (!run_c),
    .adv      (h_wrap_c),
    .wrap_c   (v_wrap_c),
    .sync_c   (v_sync_c),
    .active_c (v_active_c),
    .pos_c    (v_pos_c)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (enable) state_d = RUN;
      RUN:       if (!enable) state_d = STOP_PEND;
      STOP_PEND: begin
        if (enable) begin
          state_d = RUN;
        end else if (v_wrap_c) begin
          state_d = IDLE;
        end
      end
      default:   state_d = IDLE;
    endcase
  end

  // Output decode of the current counters; IDLE forces every output inactive.
  always_comb begin
    hs_d          = ~HS_POL;
    vs_d          = ~VS_POL;
    blank_n_d     = 1'b0;
    x_d           = '0;
    y_d           = '0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    running_d     = (state_d != IDLE);
    if (run_c) begin
      hs_d      = h_sync_c ? HS_POL : ~HS_POL;
      vs_d      = v_sync_c ? VS_POL : ~VS_POL;
      blank_n_d = h_active_c && v_active_c;
      if (blank_n_d) begin
        x_d = h_pos_c;
        y_d = v_pos_c;
      end
      line_start_d  = blank_n_d && (h_pos_c == '0);
      frame_start_d = line_start_d && (v_pos_c == '0);
    end
`ifdef VGA_TIMING_GEN_PIXREP2_EN
    xs_d        = x_d[CW-1:1];
    ys_d        = y_d[CW-1:1];
    rep_fetch_d = blank_n_d && !x_d[0];
`endif
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      blank_n_q     <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      running_q     <= 1'b0;
`ifdef VGA_TIMING_GEN_PIXREP2_EN
      xs_q          <= '0;
      ys_q          <= '0;
      rep_fetch_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= blank_n_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      running_q     <= running_d;
`ifdef VGA_TIMING_GEN_PIXREP2_EN
      xs_q          <= xs_d;
      ys_q          <= ys_d;
      rep_fetch_q   <= rep_fetch_d;
`endif
    end
  end

  assign HS          = hs_q;
  assign VS          = vs_q;
  assign blank_n     = blank_n_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign running     = running_q;
`ifdef VGA_TIMING_GEN_PIXREP2_EN
  assign xs          = xs_q;
  assign ys          = ys_q;
  assign rep_fetch   = rep_fetch_q;
`endif

endmodule
